// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: CPU major-state encodings, IOT function codes and
// small helpers used by the I/O peripherals.
package pdp8_pkg;

   localparam logic [3:0] STATE_F0 = 4'd0;
   localparam logic [3:0] STATE_F1 = 4'd1;
   localparam logic [3:0] STATE_F2 = 4'd2;
   localparam logic [3:0] STATE_F3 = 4'd3;
   localparam logic [3:0] STATE_D0 = 4'd4;
   localparam logic [3:0] STATE_D1 = 4'd5;
   localparam logic [3:0] STATE_D2 = 4'd6;
   localparam logic [3:0] STATE_D3 = 4'd7;
   localparam logic [3:0] STATE_E0 = 4'd8;
   localparam logic [3:0] STATE_E1 = 4'd9;
   localparam logic [3:0] STATE_E2 = 4'd10;
   localparam logic [3:0] STATE_E3 = 4'd11;

   localparam logic [2:0] IOP_CLEI = 3'o1;
   localparam logic [2:0] IOP_CLDI = 3'o2;
   localparam logic [2:0] IOP_CLSK = 3'o3;

   // Counter width able to hold 0..divisor-1 (divisor >= 2).
   function automatic int cnt_width(input int divisor);
      return $clog2(divisor);
   endfunction

endpackage

// File: rtl/pdp8_tick_div.sv
// Free-running modulo-DIVISOR counter; tick is high during the last count
// of each period.
module pdp8_tick_div
   import pdp8_pkg::*;
#(
   parameter int DIVISOR = 833333,
   parameter int CNT_W   = cnt_width(DIVISOR)
) (
   input  logic             clk,
   input  logic             reset,
   output logic             tick,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

   assign tick = (cnt == LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pdp8_kw_clock.sv
// KW8-style real-time clock: periodic tick latched into a flag, IOT-controlled
// interrupt enable, skip-on-flag and flag clear.
module pdp8_kw_clock
   import pdp8_pkg::*;
#(
   parameter int          DIVISOR  = 833333,
   parameter logic [5:0]  DEV_CODE = 6'o13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iot,
   input  logic [3:0]  state,
   input  logic [11:0] mb,
   input  logic [5:0]  io_select,
   output logic        io_selected,
   output logic        io_interrupt,
   output logic        io_skip
);

   localparam int CNT_W = cnt_width(DIVISOR);

   logic             tick;
   logic [CNT_W-1:0] cnt;
   logic             flag;
   logic             int_en;
   logic [2:0]       iop;
   logic             commit;
   logic             unused_bits;

   pdp8_tick_div #(
      .DIVISOR (DIVISOR),
      .CNT_W   (CNT_W)
   ) u_div (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .cnt   (cnt)
   );

   // Opcode bits above the IOP field and the raw count are not needed here.
   assign unused_bits = ^{mb[11:3], cnt};

   assign iop          = mb[2:0];
   assign io_selected  = iot && (io_select == DEV_CODE);
   assign commit       = io_selected && (state == STATE_F1);

   // Skip is combinational so the CPU sees it before the commit edge clears flag.
   assign io_skip      = io_selected && (iop == IOP_CLSK) && flag;
   assign io_interrupt = flag && int_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flag   <= 1'b0;
         int_en <= 1'b0;
      end else begin
         // A tick in the same cycle as a CLSK commit must not be lost.
         if (tick) begin
            flag <= 1'b1;
         end else if (commit && iop == IOP_CLSK) begin
            flag <= 1'b0;
         end

         if (commit && iop == IOP_CLEI) begin
            int_en <= 1'b1;
         end else if (commit && iop == IOP_CLDI) begin
            int_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pdp8_kw_clock.sv
// Directed bench for pdp8_kw_clock with DIVISOR=10: decode table plus
// hand-written sequences for tick timing, IOT commits, tick/CLSK race and reset.
module tb_pdp8_kw_clock;
   import pdp8_pkg::*;

   localparam int         DIV = 10;
   localparam logic [5:0] DEV = 6'o13;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        iot = 1'b0;
   logic [3:0]  state = STATE_F0;
   logic [11:0] mb = '0;
   logic [5:0]  io_select = '0;
   logic        io_selected;
   logic        io_interrupt;
   logic        io_skip;

   int checks = 0;
   int errors = 0;
   int edges  = 0;   // rising edges since the last reset release

   pdp8_kw_clock #(
      .DIVISOR  (DIV),
      .DEV_CODE (DEV)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .iot          (iot),
      .state        (state),
      .mb           (mb),
      .io_select    (io_select),
      .io_selected  (io_selected),
      .io_interrupt (io_interrupt),
      .io_skip      (io_skip)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iot;
      logic [3:0]  state;
      logic [11:0] mb;
      logic [5:0]  sel;
      logic        exp_sel;
      logic        exp_skip;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      iot       = 1'b0;
      state     = STATE_F0;
      mb        = '0;
      io_select = '0;
   endtask

   task automatic drive(input logic i, input logic [3:0] s, input logic [11:0] m, input logic [5:0] sel);
      iot       = i;
      state     = s;
      mb        = m;
      io_select = sel;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edges++;
   endtask

   task automatic advance_to(input int phase);
      for (int k = 0; k < DIV && (edges % DIV) != phase; k++) step();
   endtask

   // Reads the flag through io_skip using a CLSK outside F1, which never commits.
   task automatic probe_flag(output logic f);
      drive(1'b1, STATE_F0, 12'o0003, DEV);
      #1;
      f = io_skip;
      idle();
   endtask

   task automatic commit_iot(input logic [2:0] code);
      drive(1'b1, STATE_F1, {9'o0, code}, DEV);
      step();
      idle();
   endtask

   logic f;

   initial begin
      //            iot  state     mb        sel    sel  skip   (flag = 1)
      vecs[0] = '{1'b1, STATE_F0, 12'o0003, 6'o13, 1'b1, 1'b1};
      vecs[1] = '{1'b1, STATE_F2, 12'o0003, 6'o13, 1'b1, 1'b1};
      vecs[2] = '{1'b0, STATE_F0, 12'o0003, 6'o13, 1'b0, 1'b0};
      vecs[3] = '{1'b1, STATE_F0, 12'o0003, 6'o03, 1'b0, 1'b0};
      vecs[4] = '{1'b1, STATE_F0, 12'o0001, 6'o13, 1'b1, 1'b0};
      vecs[5] = '{1'b1, STATE_F0, 12'o0002, 6'o13, 1'b1, 1'b0};
      vecs[6] = '{1'b1, STATE_F0, 12'o7773, 6'o13, 1'b1, 1'b1};
      vecs[7] = '{1'b1, STATE_F0, 12'o0004, 6'o13, 1'b1, 1'b0};
      vecs[8] = '{1'b1, STATE_F0, 12'o0003, 6'o12, 1'b0, 1'b0};

      // Reset state
      #3 reset = 1'b0;
      #1;
      check("rst_interrupt", io_interrupt, 1'b0);
      drive(1'b1, STATE_F0, 12'o0003, DEV);
      #1;
      check("rst_selected_follows", io_selected, 1'b1);
      check("rst_skip", io_skip, 1'b0);
      idle();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      edges = 0;

      // 1: first tick on edge 10
      repeat (9) step();
      probe_flag(f);
      check("s1_flag_before_tick", f, 1'b0);
      step();
      probe_flag(f);
      check("s1_flag_after_tick", f, 1'b1);
      check("s1_no_interrupt", io_interrupt, 1'b0);

      // Decode table (flag = 1, int_en = 0); inputs removed before each edge
      for (int i = 0; i < 9; i++) begin
         step();
         drive(vecs[i].iot, vecs[i].state, vecs[i].mb, vecs[i].sel);
         #1;
         check($sformatf("vec%0d_selected", i), io_selected, vecs[i].exp_sel);
         check($sformatf("vec%0d_skip", i), io_skip, vecs[i].exp_skip);
         check($sformatf("vec%0d_interrupt", i), io_interrupt, 1'b0);
         idle();
      end

      // 2: CLEI then CLDI
      commit_iot(IOP_CLEI);
      check("s2_clei_interrupt", io_interrupt, 1'b1);
      commit_iot(IOP_CLDI);
      check("s2_cldi_interrupt", io_interrupt, 1'b0);
      probe_flag(f);
      check("s2_flag_kept", f, 1'b1);

      // 3: CLSK away from the tick
      advance_to(2);
      drive(1'b1, STATE_F1, 12'o0003, DEV);
      #1;
      check("s3_skip_before_commit", io_skip, 1'b1);
      step();
      check("s3_skip_after_commit", io_skip, 1'b0);
      idle();
      probe_flag(f);
      check("s3_flag_cleared", f, 1'b0);

      // 4: CLSK commit edge coincides with the tick
      advance_to(9);
      probe_flag(f);
      check("s4_flag_clear_pre", f, 1'b0);
      step();
      probe_flag(f);
      check("s4_flag_set", f, 1'b1);
      advance_to(9);
      drive(1'b1, STATE_F1, 12'o0003, DEV);
      #1;
      check("s4_skip_at_tick", io_skip, 1'b1);
      step();
      idle();
      probe_flag(f);
      check("s4_tick_wins", f, 1'b1);

      // 5: non-committing CLEI variants (flag = 1 so interrupt exposes int_en)
      drive(1'b1, STATE_F1, 12'o0001, 6'o03);
      #1;
      check("s5_wrongdev_selected", io_selected, 1'b0);
      check("s5_wrongdev_skip", io_skip, 1'b0);
      step();
      idle();
      check("s5_wrongdev_int", io_interrupt, 1'b0);
      drive(1'b0, STATE_F1, 12'o0001, DEV);
      #1;
      check("s5_noiot_selected", io_selected, 1'b0);
      step();
      idle();
      check("s5_noiot_int", io_interrupt, 1'b0);
      drive(1'b1, STATE_F0, 12'o0001, DEV);
      step();
      idle();
      check("s5_f0_int", io_interrupt, 1'b0);
      // Held F1 repeats the commit harmlessly
      drive(1'b1, STATE_F1, 12'o0001, DEV);
      step();
      step();
      idle();
      check("s5_clei_held", io_interrupt, 1'b1);

      // 6: asynchronous reset mid-count
      advance_to(5);
      check("s6_int_before_reset", io_interrupt, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("s6_int_async_clear", io_interrupt, 1'b0);
      probe_flag(f);
      check("s6_flag_async_clear", f, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      edges = 0;
      repeat (9) step();
      probe_flag(f);
      check("s6_no_early_tick", f, 1'b0);
      step();
      probe_flag(f);
      check("s6_tick_after_10", f, 1'b1);
      check("s6_int_en_cleared", io_interrupt, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
